fifo_wr_arbiter: RTL

//   Round-robin write-port arbiter for one shared fifo instance.
//   - N producers each present a request plus a W-bit word.
//   - The block grants one producer at a time and drives the fifo write enable and data.
//   - It honours fifo back-pressure (full) and limits each grant to BURST accepted beats
//     so no producer can starve the others.

---
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between N producers, the round-robin arbiter and one shared fifo.
// The producer/fifo side uses master; the arbiter uses slave.
interface fifo_wr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   in_req;
  logic [N*W-1:0] in_data;
  logic           in_fifo_full;
  logic [N-1:0]   o_gnt;
  logic [N-1:0]   o_ack;
  logic           o_fifo_w_en;
  logic [W-1:0]   o_fifo_data;

  modport master (
    output in_req, in_data, in_fifo_full,
    input  o_gnt, o_ack, o_fifo_w_en, o_fifo_data
  );

  modport slave (
    input  in_req, in_data, in_fifo_full,
    output o_gnt, o_ack, o_fifo_w_en, o_fifo_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter for one shared fifo, with a per-grant burst limit.
// Define FIFO_WR_ARBITER_STATS_EN to add saturating beat/stall counters.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int BURST = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [15:0]      o_beat_cnt,
  output logic [15:0]      o_stall_cnt
`endif
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] rrPtr_q, rrPtr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [CW-1:0] beatCnt_q, beatCnt_d;

  logic          reqG;
  logic          accept;
  logic          lastBeat;
  logic          doRelease;
  logic [IW-1:0] nextPtr;

  // First requester at or after p, searching circularly; scanning downward lets the nearest win.
  function automatic logic [IW-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(p) + k) % N);
      if (req[idx]) pick = idx;
    end
  endfunction

  assign reqG      = bus.in_req[g_q];
  assign accept    = (state_q == GRANT) && reqG && !bus.in_fifo_full;
  assign lastBeat  = accept && (beatCnt_q == CW'(BURST - 1));
  assign doRelease = (state_q == GRANT) && (!reqG || lastBeat);
  assign nextPtr   = IW'((int'(g_q) + 1) % N);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rrPtr_q   <= '0;
      gnt_q     <= '0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rrPtr_q   <= rrPtr_d;
      gnt_q     <= gnt_d;
      beatCnt_q <= beatCnt_d;
    end
  end

  // On release the next owner is chosen on the same edge, so back-to-back grants have no bubble.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    rrPtr_d   = rrPtr_q;
    gnt_d     = gnt_q;
    beatCnt_d = beatCnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.in_req) begin
          state_d     = GRANT;
          g_d         = pick(bus.in_req, rrPtr_q);
          gnt_d       = '0;
          gnt_d[g_d]  = 1'b1;
          beatCnt_d   = '0;
        end
      end
      GRANT: begin
        if (doRelease) begin
          rrPtr_d = nextPtr;
          if (|bus.in_req) begin
            g_d        = pick(bus.in_req, nextPtr);
            gnt_d      = '0;
            gnt_d[g_d] = 1'b1;
            beatCnt_d  = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (accept) begin
          beatCnt_d = beatCnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_gnt       = gnt_q;
    bus.o_fifo_w_en = accept;
    bus.o_ack       = '0;
    bus.o_fifo_data = '0;
    if (accept) bus.o_ack[g_q] = 1'b1;
    if (state_q == GRANT) bus.o_fifo_data = bus.in_data[g_q*W +: W];
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] beatTot_q;
  logic [15:0] stallTot_q;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      beatTot_q  <= '0;
      stallTot_q <= '0;
    end else begin
      if (accept && beatTot_q != 16'hFFFF) beatTot_q <= beatTot_q + 16'd1;
      if ((state_q == GRANT) && reqG && bus.in_fifo_full && stallTot_q != 16'hFFFF)
        stallTot_q <= stallTot_q + 16'd1;
    end
  end

  assign o_beat_cnt  = beatTot_q;
  assign o_stall_cnt = stallTot_q;
`endif

endmodule
